// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter state encoding and the default byte width.
package uart_pkg;

    localparam int DBIT_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted req scanning from ptr upward, wrapping at N_REQ.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Modulo keeps the scan inside 0..N_REQ-1 for non-power-of-two N_REQ.
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX FIFO write port among N_REQ byte streams.
//   state   | meaning
//   ST_IDLE | no grant held; pick next requester from ptr
//   ST_SEND | owner holds the transmitter until last, MAX_LEN bytes, or withdrawal
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int DBIT    = DBIT_DEF,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      valid,
    input  logic [N_REQ-1:0]      last,
    input  logic [N_REQ*DBIT-1:0] data,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic                  trunc,
    output logic                  wr_uart,
    output logic [DBIT-1:0]       w_data,
    input  logic                  tx_full
);

    arb_state_t       state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] owner_n, ptr, ptr_n, next_ptr, sel_idx;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             busy_n, trunc_n, found, take, rel;
    logic             own_req, own_valid, own_last;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (sel_idx)
    );

    assign own_req   = req[owner];
    assign own_valid = valid[owner];
    assign own_last  = last[owner];
    assign take      = (state == ST_SEND) && own_valid && !tx_full;
    assign wr_uart   = take;
    assign w_data    = data[int'(owner)*DBIT +: DBIT];
    assign next_ptr  = (int'(owner) == N_REQ-1) ? '0 : owner + IDX_W'(1);

    always_comb begin
        ack = '0;
        if (take) ack[owner] = 1'b1;
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        busy_n  = busy;
        trunc_n = 1'b0;
        rel     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    owner_n = sel_idx;
                    gnt_n   = N_REQ'(1) << sel_idx;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (take) cnt_n = cnt + LEN_W'(1);
                // A last byte on the MAX_LEN-th transfer is a clean end, not a truncation.
                if (take && own_last) begin
                    rel = 1'b1;
                end else if (take && (cnt == LEN_W'(MAX_LEN-1))) begin
                    rel     = 1'b1;
                    trunc_n = 1'b1;
                end else if (!own_req && !own_valid) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = next_ptr;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            trunc <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            trunc <= trunc_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, packet lock, backpressure, truncation, withdrawal, reset.
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int IDX_W   = 2;
    localparam int DBIT    = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_REQ-1:0]      req, valid, last;
    logic [N_REQ*DBIT-1:0] data;
    logic [N_REQ-1:0]      gnt, ack;
    logic [IDX_W-1:0]      owner;
    logic                  busy, trunc, wr_uart, tx_full;
    logic [DBIT-1:0]       w_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int tr_cnt = 0;

    uart_tx_arbiter #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .DBIT    (DBIT),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .valid   (valid),
        .last    (last),
        .data    (data),
        .gnt     (gnt),
        .ack     (ack),
        .owner   (owner),
        .busy    (busy),
        .trunc   (trunc),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .tx_full (tx_full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_uart) wr_cnt++;
        if (trunc) tr_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        data[i*DBIT +: DBIT] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; valid = 4'b1111; last = '0; data = '0; tx_full = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({gnt, busy, owner, trunc, wr_uart, ack} !== {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state got gnt=%b busy=%b owner=%0d trunc=%b wr=%b ack=%b exp all zero",
                     gnt, busy, owner, trunc, wr_uart, ack);
        end
        req = '0; valid = '0;
        reset = 1'b0;
        cyc();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_idle got gnt=%b busy=%b exp 0000 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        int w0;
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        w0 = wr_cnt;
        req = 4'b0100;
        cyc();
        checks++;
        if ({gnt, busy, owner} !== {4'b0100, 1'b1, 2'd2}) begin
            errors++; $display("FAIL single_grant got gnt=%b busy=%b owner=%0d exp 0100 1 2", gnt, busy, owner);
        end
        valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            set_byte(2, exp_b[i]);
            last = (i == 2) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if ({wr_uart, w_data, ack} !== {1'b1, exp_b[i], 4'b0100}) begin
                errors++;
                $display("FAIL single_byte%0d got wr=%b data=%h ack=%b exp 1 %h 0100", i, wr_uart, w_data, ack, exp_b[i]);
            end
            cyc();
        end
        checks++;
        if ({gnt, busy, trunc} !== 6'b0) begin
            errors++; $display("FAIL single_release got gnt=%b busy=%b trunc=%b exp 0000 0 0", gnt, busy, trunc);
        end
        req = 4'b1111; valid = '0; last = '0;
        cyc();
        checks++;
        if ({gnt, owner} !== {4'b1000, 2'd3}) begin
            errors++; $display("FAIL single_ptr3 got gnt=%b owner=%0d exp 1000 3", gnt, owner);
        end
        req = '0;
        cyc();
        checks++;
        if (gnt !== 4'b0000 || wr_cnt - w0 != 3) begin
            errors++; $display("FAIL single_count got gnt=%b writes=%0d exp 0000 3", gnt, wr_cnt - w0);
        end
    endtask

    task automatic test_fairness();
        int order [5];
        logic [7:0] eb;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        for (int i = 0; i < N_REQ; i++) set_byte(i, 8'hF0 + 8'(i));
        req = 4'b1111; valid = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            eb = 8'hF0 + 8'(order[k]);
            checks++;
            if ({gnt, owner, wr_uart, w_data} !== {4'(1 << order[k]), 2'(order[k]), 1'b1, eb}) begin
                errors++;
                $display("FAIL fair_grant%0d got gnt=%b owner=%0d wr=%b data=%h exp owner %0d data %h",
                         k, gnt, owner, wr_uart, w_data, order[k], eb);
            end
            cyc();
            if (k == 4) begin
                req = '0; valid = '0; last = '0;
            end
            checks++;
            if ({gnt, busy, wr_uart} !== 6'b0) begin
                errors++; $display("FAIL fair_gap%0d got gnt=%b busy=%b wr=%b exp idle", k, gnt, busy, wr_uart);
            end
        end
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = wr_cnt;
        req = 4'b0010;
        cyc();
        checks++;
        if ({gnt, owner} !== {4'b0010, 2'd1}) begin
            errors++; $display("FAIL bp_grant got gnt=%b owner=%0d exp 0010 1", gnt, owner);
        end
        valid = 4'b0011; last = 4'b0001;
        set_byte(0, 8'hEE); set_byte(1, 8'h55);
        #1;
        checks++;
        if ({wr_uart, w_data, ack} !== {1'b1, 8'h55, 4'b0010}) begin
            errors++; $display("FAIL bp_first got wr=%b data=%h ack=%b exp 1 55 0010", wr_uart, w_data, ack);
        end
        cyc();
        tx_full = 1'b1; set_byte(1, 8'h66); last = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({wr_uart, ack, gnt} !== {1'b0, 4'b0000, 4'b0010}) begin
                errors++; $display("FAIL bp_stall%0d got wr=%b ack=%b gnt=%b exp 0 0000 0010", i, wr_uart, ack, gnt);
            end
            cyc();
        end
        tx_full = 1'b0;
        #1;
        checks++;
        if ({wr_uart, w_data, ack} !== {1'b1, 8'h66, 4'b0010}) begin
            errors++; $display("FAIL bp_second got wr=%b data=%h ack=%b exp 1 66 0010", wr_uart, w_data, ack);
        end
        cyc();
        req = '0; valid = '0; last = '0;
        checks++;
        if (gnt !== 4'b0000 || wr_cnt - w0 != 2) begin
            errors++; $display("FAIL bp_count got gnt=%b writes=%0d exp 0000 2", gnt, wr_cnt - w0);
        end
    endtask

    task automatic test_truncation();
        int w0, t0;
        w0 = wr_cnt; t0 = tr_cnt;
        req = 4'b0001; valid = 4'b0001; last = '0;
        cyc();
        for (int i = 0; i < MAX_LEN; i++) begin
            set_byte(0, 8'(i));
            #1;
            checks++;
            if ({gnt, wr_uart, w_data} !== {4'b0001, 1'b1, 8'(i)}) begin
                errors++; $display("FAIL trunc_byte%0d got gnt=%b wr=%b data=%h exp 0001 1 %h", i, gnt, wr_uart, w_data, 8'(i));
            end
            cyc();
        end
        checks++;
        if ({trunc, gnt, busy, wr_uart} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL trunc_release got trunc=%b gnt=%b busy=%b wr=%b exp 1 0000 0 0", trunc, gnt, busy, wr_uart);
        end
        cyc();
        checks++;
        if ({trunc, gnt} !== {1'b0, 4'b0001}) begin
            errors++; $display("FAIL trunc_regrant got trunc=%b gnt=%b exp 0 0001", trunc, gnt);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            set_byte(0, 8'h80 + 8'(i));
            last = (i == MAX_LEN-1) ? 4'b0001 : 4'b0000;
            cyc();
        end
        req = '0; valid = '0; last = '0;
        checks++;
        if ({trunc, gnt} !== {1'b0, 4'b0000} || wr_cnt - w0 != 2*MAX_LEN || tr_cnt - t0 != 1) begin
            errors++;
            $display("FAIL trunc_lastboundary got trunc=%b gnt=%b writes=%0d truncs=%0d exp 0 0000 %0d 1",
                     trunc, gnt, wr_cnt - w0, tr_cnt - t0, 2*MAX_LEN);
        end
    endtask

    task automatic test_withdraw();
        int w0;
        w0 = wr_cnt;
        req = 4'b1001;
        cyc();
        checks++;
        if ({gnt, owner} !== {4'b1000, 2'd3}) begin
            errors++; $display("FAIL wd_grant got gnt=%b owner=%0d exp 1000 3", gnt, owner);
        end
        valid = 4'b1000; set_byte(3, 8'hA0);
        cyc();
        req = '0; valid = '0;
        #1;
        checks++;
        if ({wr_uart, ack} !== 5'b0) begin
            errors++; $display("FAIL wd_nowrite got wr=%b ack=%b exp 0 0000", wr_uart, ack);
        end
        cyc();
        checks++;
        if ({gnt, busy, owner} !== {4'b0000, 1'b0, 2'd3} || wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL wd_release got gnt=%b busy=%b owner=%0d writes=%0d exp 0000 0 3 1", gnt, busy, owner, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        req = 4'b0100;
        cyc();
        valid = 4'b0100; set_byte(2, 8'h11);
        cyc();
        set_byte(2, 8'h22);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, wr_uart, ack, owner} !== {4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0}) begin
            errors++;
            $display("FAIL rst_mid got gnt=%b busy=%b wr=%b ack=%b owner=%0d exp all zero", gnt, busy, wr_uart, ack, owner);
        end
        cyc();
        reset = 1'b0; req = 4'b0010; valid = '0;
        cyc();
        checks++;
        if ({gnt, owner, busy} !== {4'b0010, 2'd1, 1'b1}) begin
            errors++; $display("FAIL rst_regrant got gnt=%b owner=%0d busy=%b exp 0010 1 1", gnt, owner, busy);
        end
        req = '0;
        cyc();
        checks++;
        if (gnt !== 4'b0000 || wr_cnt - w0 != 1) begin
            errors++; $display("FAIL rst_count got gnt=%b writes=%0d exp 0000 1", gnt, wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_truncation();
        test_withdraw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
